// File: rtl/sd_pkg.sv
// Shared types and helpers for the sigma-delta CIC decimator.
package sd_pkg;
  typedef enum logic [1:0] {PRIME0, PRIME1, RUN} prime_e;

  // bitstream level that stands for +1; the other level is -1
  localparam logic BS_POS = 1'b1;

  function automatic int sd_width(input int log2r);
    return 2 * log2r + 2;
  endfunction
endpackage

// File: rtl/sd_integrator.sv
// W-bit wrap-around accumulator with enable, synchronous clear and async active-low reset.
module sd_integrator #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] acc
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + inc;
  end
endmodule

// File: rtl/sd_cic_decimator.sv
// 2nd-order CIC decimator (ratio 2^LOG2R) turning a 1-bit sigma-delta stream into W-bit samples.
module sd_cic_decimator
  import sd_pkg::*;
#(
  parameter  int LOG2R = 6,
  localparam int W     = sd_width(LOG2R)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bs_in,
  input  logic                bs_valid,
  input  logic                sync_clr,
  output logic signed [W-1:0] dout,
  output logic                dout_valid
);
  localparam int STAGES = 2;
  localparam logic [LOG2R-1:0] PH_LAST = '1;

  logic                 accept;
  logic [W-1:0]         x, i1, i2;
  logic [W-1:0]         d_prev, c1, c2, c1_new;
  logic [LOG2R-1:0]     phase;
  logic [STAGES:0]      vld_pipe;
  prime_e               state;

  // a bit arriving together with sync_clr is dropped
  assign accept = bs_valid & ~sync_clr;
  assign x      = (bs_in == BS_POS) ? W'(1) : {W{1'b1}};

  sd_integrator #(.W(W)) u_int1 (
    .clk(clk), .reset(reset), .clr(sync_clr), .en(accept), .inc(x),  .acc(i1)
  );
  sd_integrator #(.W(W)) u_int2 (
    .clk(clk), .reset(reset), .clr(sync_clr), .en(accept), .inc(i1), .acc(i2)
  );

  // i2 already holds the phase-last update when the strobe is seen
  assign c1_new = i2 - d_prev;

  // vld_pipe[0]: decimation strobe, [1]: output pending, [2]: dout_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      vld_pipe <= '0;
      d_prev   <= '0;
      c1       <= '0;
      c2       <= '0;
      dout     <= '0;
      state    <= PRIME0;
    end else if (sync_clr) begin
      phase    <= '0;
      vld_pipe <= '0;
      d_prev   <= '0;
      c1       <= '0;
      c2       <= '0;
      state    <= PRIME0;
    end else begin
      if (accept) phase <= phase + 1'b1;
      vld_pipe[0] <= accept && (phase == PH_LAST);
      vld_pipe[1] <= vld_pipe[0] && (state == RUN);
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[0]) begin
        d_prev <= i2;
        c1     <= c1_new;
        c2     <= c1_new - c1;
        case (state)
          PRIME0:  state <= PRIME1;
          PRIME1:  state <= RUN;
          default: state <= RUN;
        endcase
      end
      if (vld_pipe[1]) dout <= c2;
    end
  end

  assign dout_valid = vld_pipe[STAGES];
endmodule
